// File: rtl/xcache_param_pkg.sv
// Shared xcache interconnect parameters and the return-path tag types.
package xcache_param_pkg;

    localparam int unsigned MEM_TYPE_SCALAR = 0;
    localparam int unsigned MEM_TYPE_ARRAY  = 1;
    localparam int unsigned MEM_TYPE_CYCLIC = 2;
    localparam int unsigned MEM_TYPE_NUM    = 3;

    localparam int unsigned BANK_NUM [MEM_TYPE_NUM] = '{4, 4, 4};

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int unsigned MAX_BANK_NUM =
        max3(BANK_NUM[MEM_TYPE_SCALAR], BANK_NUM[MEM_TYPE_ARRAY], BANK_NUM[MEM_TYPE_CYCLIC]);
    localparam int unsigned TAG_IDX_W = (MAX_BANK_NUM > 1) ? $clog2(MAX_BANK_NUM) : 1;

    typedef enum logic [1:0] {
        RESP_SCALAR = 2'd0,
        RESP_ARRAY  = 2'd1,
        RESP_CYCLIC = 2'd2,
        RESP_ERR    = 2'd3
    } resp_mtype_e;

    typedef struct packed {
        resp_mtype_e          mtype;
        logic [TAG_IDX_W-1:0] idx;
    } resp_tag_t;

endpackage

// File: rtl/resp_tag_fifo.sv
// In-order tag FIFO: synchronous write, asynchronous (combinational) head read.
module resp_tag_fifo
    import xcache_param_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  resp_tag_t                  push_tag,
    input  logic                       pop,
    output resp_tag_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    resp_tag_t   mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Extra pointer MSB separates full from empty after wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/bank_resp_collector.sv
// xcache bank return path: per-bank hold registers, reordered to request order via a tag FIFO.
module bank_resp_collector
    import xcache_param_pkg::*;
#(
    parameter int unsigned NS          = BANK_NUM[MEM_TYPE_SCALAR],
    parameter int unsigned NA          = BANK_NUM[MEM_TYPE_ARRAY],
    parameter int unsigned NC          = BANK_NUM[MEM_TYPE_CYCLIC],
    parameter int unsigned DW          = 32,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [NS-1:0]                  matched_scalar,
    input  logic [NA-1:0]                  matched_array,
    input  logic [NC-1:0]                  matched_cyclic,
    input  logic [NS-1:0]                  scalar_rvalid,
    input  logic [NS-1:0][DW-1:0]          scalar_rdata,
    output logic [NS-1:0]                  scalar_rready,
    input  logic [NA-1:0]                  array_rvalid,
    input  logic [NA-1:0][DW-1:0]          array_rdata,
    output logic [NA-1:0]                  array_rready,
    input  logic [NC-1:0]                  cyclic_rvalid,
    input  logic [NC-1:0][DW-1:0]          cyclic_rdata,
    output logic [NC-1:0]                  cyclic_rready,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [DW-1:0]                  resp_data,
    output logic                           resp_err,
    output logic [$clog2(OUTSTANDING):0]   outstanding_cnt
);

    localparam int unsigned NB    = NS + NA + NC;
    localparam int unsigned SEL_W = $clog2(NB);

    // Banks are flattened as scalar, then array, then cyclic.
    logic [NB-1:0]          bank_rvalid;
    logic [NB-1:0][DW-1:0]  bank_rdata;
    logic [NB-1:0]          hold_valid;
    logic [NB-1:0][DW-1:0]  hold_data;

    resp_tag_t              push_tag;
    resp_tag_t              head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   pop_bank;
    logic [SEL_W-1:0]       sel;

    assign bank_rvalid = {cyclic_rvalid, array_rvalid, scalar_rvalid};
    assign bank_rdata  = {cyclic_rdata, array_rdata, scalar_rdata};

    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready && !req_we;

    // Tag encode: anything other than exactly one match bit becomes an error tag.
    always_comb begin
        push_tag.mtype = RESP_ERR;
        push_tag.idx   = '0;
        if ($countones({matched_scalar, matched_array, matched_cyclic}) == 1) begin
            for (int i = 0; i < NS; i++)
                if (matched_scalar[i]) begin
                    push_tag.mtype = RESP_SCALAR;
                    push_tag.idx   = TAG_IDX_W'(i);
                end
            for (int i = 0; i < NA; i++)
                if (matched_array[i]) begin
                    push_tag.mtype = RESP_ARRAY;
                    push_tag.idx   = TAG_IDX_W'(i);
                end
            for (int i = 0; i < NC; i++)
                if (matched_cyclic[i]) begin
                    push_tag.mtype = RESP_CYCLIC;
                    push_tag.idx   = TAG_IDX_W'(i);
                end
        end
    end

    resp_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding_cnt)
    );

    always_comb begin
        sel = '0;
        case (head.mtype)
            RESP_SCALAR: sel = SEL_W'(head.idx);
            RESP_ARRAY:  sel = SEL_W'(NS) + SEL_W'(head.idx);
            RESP_CYCLIC: sel = SEL_W'(NS + NA) + SEL_W'(head.idx);
            default:     sel = '0;
        endcase
    end

    // Head response mux; error tags answer immediately without a bank.
    always_comb begin
        resp_valid = 1'b0;
        resp_data  = '0;
        resp_err   = 1'b0;
        if (!fifo_empty) begin
            if (head.mtype == RESP_ERR) begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end else begin
                resp_valid = hold_valid[sel];
                resp_data  = hold_data[sel];
            end
        end
    end

    assign pop      = resp_valid && resp_ready;
    assign pop_bank = pop && (head.mtype != RESP_ERR);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_valid <= '0;
            hold_data  <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (pop_bank && (sel == SEL_W'(b))) begin
                    hold_valid[b] <= 1'b0;
                end else if (bank_rvalid[b] && !hold_valid[b]) begin
                    hold_valid[b] <= 1'b1;
                    hold_data[b]  <= bank_rdata[b];
                end
            end
        end
    end

    // A full hold register stalls its bank; no same-cycle bypass on pop.
    assign scalar_rready = ~hold_valid[NS-1:0];
    assign array_rready  = ~hold_valid[NS+NA-1:NS];
    assign cyclic_rready = ~hold_valid[NB-1:NS+NA];

endmodule
